// File: rtl/freq_sweeper.sv
// -----------------------------------------------------------------------------
// freq_sweeper
//   Consumer stage sitting directly behind the tone ring buffer. It fetches
//   the ring front word and pops it. It then presents the word on a
//   valid/ready stream toward the DDS/NCO. After each accepted tone it idles
//   for a programmable dwell time before fetching the next one. Sweep
//   boundaries are taken from the ring's last flag. A change in the ring
//   occupancy means the ring was rewritten, and the sweep aborts back to IDLE.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   enable       : run the sweep; only acted on at fetch boundaries
//   dwell        : idle cycles inserted after each output handshake
//   ring_dout    : ring front word          ring_ready : front word valid
//   ring_index   : index of front word      ring_count : stored tone count
//   ring_last    : front word is last entry ring_rd_en : pop front word
//   freq_out     : tone word to DDS         freq_index : ring index of tone
//   freq_first   : tone starts a sweep      freq_valid : output valid
//   freq_ready   : downstream accept        sweep_done : last-entry handshake
//   sweep_cnt    : completed sweeps (wraps) busy       : not IDLE
// -----------------------------------------------------------------------------
module freq_sweeper #(
   parameter int DATA_W  = 14,
   parameter int ADDR_W  = 7,
   parameter int CNT_W   = 8,
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [DATA_W-1:0]  ring_dout,
   input  logic               ring_ready,
   input  logic [ADDR_W-1:0]  ring_index,
   input  logic [CNT_W-1:0]   ring_count,
   input  logic               ring_last,
   output logic               ring_rd_en,
   output logic [DATA_W-1:0]  freq_out,
   output logic [ADDR_W-1:0]  freq_index,
   output logic               freq_first,
   output logic               freq_valid,
   input  logic               freq_ready,
   output logic               sweep_done,
   output logic [15:0]        sweep_cnt,
   output logic               busy
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_POP     = 3'd2,
      S_PRESENT = 3'd3,
      S_DWELL   = 3'd4
   } state_t;

   state_t               r_state;
   logic [CNT_W-1:0]     r_count_q;
   logic                 r_first_pend;
   logic                 r_last_q;
   logic [DWELL_W-1:0]   r_dwell_cnt;
   logic [DATA_W-1:0]    r_freq_out;
   logic [ADDR_W-1:0]    r_freq_index;
   logic                 r_freq_first;
   logic                 r_freq_valid;
   logic [15:0]          r_sweep_cnt;

   logic                 w_change;
   logic                 w_pop;
   logic                 w_hs;

   // Any change in occupancy means the ring was written behind our back.
   assign w_change   = (ring_count != r_count_q);
   // Pop only when the front word is actually valid, so a stall in POP
   // never loses or duplicates a pop.
   assign w_pop      = (r_state == S_POP) && ring_ready;
   assign w_hs       = (r_state == S_PRESENT) && r_freq_valid && freq_ready;

   assign ring_rd_en = w_pop;
   // An aborting cycle takes priority over the handshake, so no boundary
   // is reported for a sweep that is being thrown away.
   assign sweep_done = w_hs && r_last_q && !w_change;
   assign freq_out   = r_freq_out;
   assign freq_index = r_freq_index;
   assign freq_first = r_freq_first;
   assign freq_valid = r_freq_valid;
   assign sweep_cnt  = r_sweep_cnt;
   assign busy       = (r_state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_count_q    <= '0;
         r_first_pend <= 1'b1;
         r_last_q     <= 1'b0;
         r_dwell_cnt  <= '0;
         r_freq_out   <= '0;
         r_freq_index <= '0;
         r_freq_first <= 1'b0;
         r_freq_valid <= 1'b0;
         r_sweep_cnt  <= '0;
      end else begin
         r_count_q <= ring_count;
         if (w_change && (r_state != S_IDLE)) begin
            // Abort: the only case where valid is withdrawn without a
            // handshake. The next word issued restarts a sweep.
            r_state      <= S_IDLE;
            r_freq_valid <= 1'b0;
            r_first_pend <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (enable && (ring_count != '0) && !w_change)
                     r_state <= S_FETCH;
               end
               // Fetch boundary: enable and occupancy are sampled here only
               S_FETCH: begin
                  if (!enable || (ring_count == '0)) begin
                     r_state <= S_IDLE;
                  end else if (ring_ready) begin
                     r_freq_out   <= ring_dout;
                     r_freq_index <= ring_index;
                     r_last_q     <= ring_last;
                     r_freq_first <= r_first_pend;
                     r_state      <= S_POP;
                  end
               end
               // Pop stage: wait out any ring_ready gap, then issue one pop
               S_POP: begin
                  if (w_pop) begin
                     r_state      <= S_PRESENT;
                     r_freq_valid <= 1'b1;
                  end
               end
               // Present stage: word held stable until accepted
               S_PRESENT: begin
                  if (w_hs) begin
                     r_freq_valid <= 1'b0;
                     r_dwell_cnt  <= dwell;
                     r_first_pend <= r_last_q;
                     if (r_last_q)
                        r_sweep_cnt <= r_sweep_cnt + 16'd1;
                     r_state <= (dwell != '0) ? S_DWELL : S_FETCH;
                  end
               end
               // Dwell stage: exactly 'dwell' cycles spent here
               S_DWELL: begin
                  r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
                  if (r_dwell_cnt <= DWELL_W'(1))
                     r_state <= S_FETCH;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_freq_sweeper.sv
// -----------------------------------------------------------------------------
// tb_freq_sweeper
//   Directed bench for freq_sweeper. A small ring model supplies the front
//   word and advances on each pop. One table of per-cycle records covers the
//   basic sweep. Hand-written sequences cover dwell, back-pressure, ring_ready
//   gaps, abort on ring rewrite, single-entry rings and reset mid-dwell.
// -----------------------------------------------------------------------------
module tb_freq_sweeper;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [15:0] dwell;
   logic [13:0] ring_dout;
   logic        ring_ready;
   logic [6:0]  ring_index;
   logic [7:0]  ring_count;
   logic        ring_last;
   logic        ring_rd_en;
   logic [13:0] freq_out;
   logic [6:0]  freq_index;
   logic        freq_first;
   logic        freq_valid;
   logic        freq_ready;
   logic        sweep_done;
   logic [15:0] sweep_cnt;
   logic        busy;

   always #5 clk = ~clk;

   freq_sweeper dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .dwell      (dwell),
      .ring_dout  (ring_dout),
      .ring_ready (ring_ready),
      .ring_index (ring_index),
      .ring_count (ring_count),
      .ring_last  (ring_last),
      .ring_rd_en (ring_rd_en),
      .freq_out   (freq_out),
      .freq_index (freq_index),
      .freq_first (freq_first),
      .freq_valid (freq_valid),
      .freq_ready (freq_ready),
      .sweep_done (sweep_done),
      .sweep_cnt  (sweep_cnt),
      .busy       (busy)
   );

   // ---------------- ring model ----------------
   logic [13:0] ring_mem [0:7];
   logic [2:0]  ring_head = 3'd0;
   logic [7:0]  ring_cnt;
   logic        rr_en;
   logic        ring_clr;

   assign ring_dout  = ring_mem[ring_head];
   assign ring_index = {4'b0, ring_head};
   assign ring_count = ring_cnt;
   assign ring_ready = rr_en && (ring_cnt != 8'd0);
   assign ring_last  = ({5'b0, ring_head} == (ring_cnt - 8'd1));

   always @(posedge clk) begin
      if (ring_clr)
         ring_head <= 3'd0;
      else if (ring_rd_en)
         ring_head <= (({5'b0, ring_head} + 8'd1) >= ring_cnt) ? 3'd0 : ring_head + 3'd1;
   end

   // ---------------- next-cycle inputs, applied at negedge ----------------
   logic        n_rst, n_en, n_frdy, n_rr, n_clr, n_wr;
   logic [15:0] n_dw;
   logic [7:0]  n_cnt;
   logic [2:0]  n_wa;
   logic [13:0] n_wd;

   int checks = 0;
   int fails  = 0;

   task automatic cyc();
      @(negedge clk);
      rst        = n_rst;
      enable     = n_en;
      dwell      = n_dw;
      freq_ready = n_frdy;
      rr_en      = n_rr;
      ring_clr   = n_clr;
      ring_cnt   = n_cnt;
      if (n_wr) ring_mem[n_wa] = n_wd;
      n_clr = 1'b0;
      n_wr  = 1'b0;
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return {22'd0, ring_rd_en, freq_valid, freq_out, freq_index, freq_first,
              sweep_done, sweep_cnt, busy};
   endfunction

   // Step until freq_valid is seen; reports cycles taken, pops seen and the
   // cycle of the first pop.
   task automatic wait_valid(input string nm, input int max, output int cn,
                             output int rn, output int ra);
      bit seen;
      cn = 0; rn = 0; ra = 0; seen = 1'b0;
      while (!seen && cn < max) begin
         cyc();
         cn++;
         if (ring_rd_en) begin
            rn++;
            if (ra == 0) ra = cn;
         end
         if (freq_valid) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         fails++;
         $display("FAIL %s: no freq_valid within %0d cycles", nm, max);
      end
   endtask

   // ---------------- table of per-cycle vectors ----------------
   typedef struct {
      logic        en;
      logic [15:0] dw;
      logic        frdy;
      logic        rr;
      logic        x_rd;
      logic        x_vld;
      logic [13:0] x_out;
      logic [6:0]  x_idx;
      logic        x_first;
      logic        x_done;
      logic [15:0] x_cnt;
      logic        x_busy;
   } vec_t;

   function automatic vec_t mk(input logic en, input logic [15:0] dw, input logic frdy,
                               input logic rr, input logic rd, input logic vld,
                               input logic [13:0] o, input logic [6:0] idx,
                               input logic f, input logic d, input logic [15:0] c,
                               input logic b);
      vec_t v;
      v.en = en; v.dw = dw; v.frdy = frdy; v.rr = rr;
      v.x_rd = rd; v.x_vld = vld; v.x_out = o; v.x_idx = idx;
      v.x_first = f; v.x_done = d; v.x_cnt = c; v.x_busy = b;
      return v;
   endfunction

   vec_t tbl [16];

   initial begin
      int cn, rn, ra;
      logic [63:0] exp_v;

      //          en dw     fr rr  rd vld out       idx f  d  cnt b
      tbl[0]  = mk(1, 16'd0, 1, 1, 0, 0, 14'h0000, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 16'd0, 1, 1, 0, 0, 14'h0000, 0, 0, 0, 0, 1);
      tbl[2]  = mk(1, 16'd0, 1, 1, 1, 0, 14'h0100, 0, 1, 0, 0, 1);
      tbl[3]  = mk(1, 16'd0, 1, 1, 0, 1, 14'h0100, 0, 1, 0, 0, 1);
      tbl[4]  = mk(1, 16'd0, 1, 1, 0, 0, 14'h0100, 0, 1, 0, 0, 1);
      tbl[5]  = mk(1, 16'd0, 1, 1, 1, 0, 14'h0200, 1, 0, 0, 0, 1);
      tbl[6]  = mk(1, 16'd0, 1, 1, 0, 1, 14'h0200, 1, 0, 0, 0, 1);
      tbl[7]  = mk(1, 16'd0, 1, 1, 0, 0, 14'h0200, 1, 0, 0, 0, 1);
      tbl[8]  = mk(1, 16'd0, 1, 1, 1, 0, 14'h0300, 2, 0, 0, 0, 1);
      tbl[9]  = mk(1, 16'd0, 1, 1, 0, 1, 14'h0300, 2, 0, 0, 0, 1);
      tbl[10] = mk(1, 16'd0, 1, 1, 0, 0, 14'h0300, 2, 0, 0, 0, 1);
      tbl[11] = mk(1, 16'd0, 1, 1, 1, 0, 14'h0400, 3, 0, 0, 0, 1);
      tbl[12] = mk(1, 16'd0, 1, 1, 0, 1, 14'h0400, 3, 0, 1, 0, 1);
      tbl[13] = mk(1, 16'd0, 1, 1, 0, 0, 14'h0400, 3, 0, 0, 1, 1);
      tbl[14] = mk(1, 16'd0, 1, 1, 1, 0, 14'h0100, 0, 1, 0, 1, 1);
      tbl[15] = mk(1, 16'd0, 1, 1, 0, 1, 14'h0100, 0, 1, 0, 1, 1);

      ring_mem[0] = 14'h0100; ring_mem[1] = 14'h0200;
      ring_mem[2] = 14'h0300; ring_mem[3] = 14'h0400;
      for (int i = 4; i < 8; i++) ring_mem[i] = 14'h0000;

      rst = 1'b1; enable = 1'b0; dwell = 16'd0; freq_ready = 1'b0;
      rr_en = 1'b0; ring_clr = 1'b1; ring_cnt = 8'd4;
      n_rst = 1'b1; n_en = 1'b0; n_dw = 16'd0; n_frdy = 1'b0; n_rr = 1'b0;
      n_cnt = 8'd4; n_clr = 1'b1; n_wr = 1'b0; n_wa = 3'd0; n_wd = 14'h0;

      // reset state
      repeat (3) cyc();
      chk("reset_outputs", outs(), 64'd0);
      n_rst = 1'b0;
      cyc();

      // four-tone sweep, dwell 0, one tone per 3 cycles
      for (int i = 0; i < 16; i++) begin
         n_en = tbl[i].en; n_dw = tbl[i].dw; n_frdy = tbl[i].frdy; n_rr = tbl[i].rr;
         cyc();
         exp_v = {22'd0, tbl[i].x_rd, tbl[i].x_vld, tbl[i].x_out, tbl[i].x_idx,
                  tbl[i].x_first, tbl[i].x_done, tbl[i].x_cnt, tbl[i].x_busy};
         chk($sformatf("vec%0d", i), outs(), exp_v);
      end

      // dwell = 5: gap after handshake, one pop per tone
      n_dw = 16'd5;
      wait_valid("dwell_a", 20, cn, rn, ra);
      chk("dwell_a_cycles", cn, 3);
      chk("dwell_a_out", freq_out, 14'h0200);
      wait_valid("dwell_b", 20, cn, rn, ra);
      chk("dwell_gap_cycles", cn, 8);
      chk("dwell_pops", rn, 1);
      chk("dwell_pop_at", ra, 7);
      chk("dwell_b_out", {freq_out, freq_index}, {14'h0300, 7'd2});

      // freq_ready held low for 10 cycles in PRESENT
      n_dw = 16'd0; n_frdy = 1'b0;
      wait_valid("hold_entry", 20, cn, rn, ra);
      chk("hold_entry_cycles", cn, 8);
      chk("hold_entry_out", {freq_out, freq_index}, {14'h0400, 7'd3});
      for (int i = 1; i < 10; i++) begin
         cyc();
         chk($sformatf("hold%0d", i), {ring_rd_en, freq_valid, freq_out, sweep_done},
             {1'b0, 1'b1, 14'h0400, 1'b0});
      end
      n_frdy = 1'b1;
      cyc();
      chk("hold_accept", {freq_valid, freq_out, sweep_done, sweep_cnt},
          {1'b1, 14'h0400, 1'b1, 16'd1});
      cyc();
      chk("hold_after", {freq_valid, sweep_cnt, busy}, {1'b0, 16'd2, 1'b1});

      // ring_ready dropped for 4 cycles while in POP
      n_rr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk($sformatf("popwait%0d", i), {ring_rd_en, freq_valid, freq_out},
             {1'b0, 1'b0, 14'h0100});
      end
      n_rr = 1'b1;
      cyc();
      chk("popwait_pop", ring_rd_en, 1'b1);
      cyc();
      chk("popwait_present", {ring_rd_en, freq_valid, freq_out, freq_index, freq_first},
          {1'b0, 1'b1, 14'h0100, 7'd0, 1'b1});

      // ring rewritten (count 4 -> 5) while in PRESENT
      n_frdy = 1'b0;
      wait_valid("abort_entry", 10, cn, rn, ra);
      chk("abort_entry_out", {freq_out, freq_index, freq_first}, {14'h0200, 7'd1, 1'b0});
      n_wr = 1'b1; n_wa = 3'd4; n_wd = 14'h0500; n_cnt = 8'd5; n_clr = 1'b1;
      cyc();
      chk("abort_cycle", {freq_valid, sweep_done, busy}, {1'b1, 1'b0, 1'b1});
      cyc();
      chk("abort_idle", {freq_valid, sweep_done, busy, sweep_cnt}, {1'b0, 1'b0, 1'b0, 16'd2});
      n_frdy = 1'b1;
      wait_valid("restart", 10, cn, rn, ra);
      chk("restart_out", {freq_out, freq_index, freq_first, sweep_cnt},
          {14'h0100, 7'd0, 1'b1, 16'd2});

      // single-entry ring with tone 0x1FFF
      n_wr = 1'b1; n_wa = 3'd0; n_wd = 14'h1FFF; n_cnt = 8'd1; n_clr = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) n_dw = 16'd4;
         wait_valid($sformatf("single%0d", k), 12, cn, rn, ra);
         chk($sformatf("single%0d", k),
             {freq_out, freq_index, freq_first, sweep_done, sweep_cnt},
             {14'h1FFF, 7'd0, 1'b1, 1'b1, 16'(2 + k)});
      end

      // reset mid-dwell
      cyc();
      chk("dwell_before_rst", {busy, freq_valid, sweep_cnt}, {1'b1, 1'b0, 16'd6});
      n_rst = 1'b1;
      cyc();
      cyc();
      chk("rst_mid_dwell", outs(), 64'd0);
      n_rst = 1'b0;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
